// File: rtl/fp_cmp_pkg.sv
// ============================================================================
// Module      : fp_cmp_pkg
// Description : Shared constants and the result-packing helper for the
//               floating-point compare arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_cmp_pkg;

    localparam int CMP_AEB_BIT   = 0;
    localparam int CMP_AGB_BIT   = 1;
    localparam int CMP_ALB_BIT   = 2;
    localparam int CMP_UNORD_BIT = 3;
    localparam int CMP_RESULT_W  = 32;

    typedef struct packed {
        logic unord;
        logic alb;
        logic agb;
        logic aeb;
    } cmp_flags_t;

    function automatic logic [CMP_RESULT_W-1:0] cmp_pack_result(input cmp_flags_t f);
        logic [CMP_RESULT_W-1:0] r;
        r                = '0;
        r[CMP_AEB_BIT]   = f.aeb;
        r[CMP_AGB_BIT]   = f.agb;
        r[CMP_ALB_BIT]   = f.alb;
        r[CMP_UNORD_BIT] = f.unord;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_compare_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker: first asserted request at
//               or after the pointer, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [TAG_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [TAG_W-1:0]   o_idx,
    output logic               o_valid
);

    localparam logic [TAG_W:0] c_NUM = (TAG_W+1)'(NUM_REQ);

    // One extra bit so ptr+k (< 2*NUM_REQ) never overflows before the wrap.
    logic [TAG_W:0] w_pos;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = {1'b0, i_ptr} + (TAG_W+1)'(k);
            if (w_pos >= c_NUM) begin
                w_pos = w_pos - c_NUM;
            end
            if (!o_valid && i_req[w_pos[TAG_W-1:0]]) begin
                o_valid                  = 1'b1;
                o_idx                    = w_pos[TAG_W-1:0];
                o_gnt[w_pos[TAG_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_compare_arbiter.sv
// ============================================================================
// Module      : fp_compare_arbiter
// Description : Round-robin sharing of one pipelined FP compare core between
//               NUM_REQ requesters, with a tag pipeline routing results back.
//               Optional macro FP_CMP_UNORDERED_EN adds the unordered flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_compare_arbiter
    import fp_cmp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_dataa,
    input  logic [32*NUM_REQ-1:0]   req_datab,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [CMP_RESULT_W-1:0] rsp_result,
    output logic                    cmp_clk_en,
    output logic [31:0]             cmp_dataa,
    output logic [31:0]             cmp_datab,
    input  logic                    cmp_aeb,
    input  logic                    cmp_agb,
    input  logic                    cmp_alb
);

    localparam int               TAG_W  = $clog2(NUM_REQ);
    localparam logic [TAG_W-1:0] c_LAST = TAG_W'(NUM_REQ - 1);

    logic [TAG_W-1:0]   r_ptr;
    logic [LATENCY:0]   r_vpipe;
    logic [TAG_W-1:0]   r_tag [0:LATENCY];
    logic [31:0]        r_dataa;
    logic [31:0]        r_datab;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [TAG_W-1:0]   w_arb_idx;
    logic               w_arb_valid;
    logic               w_issue;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic               w_unord;
    cmp_flags_t         w_flags;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // Grants are suppressed while reset is held so no requester sees a
    // handshake that the cleared pipeline would never answer.
    assign w_issue = w_arb_valid & ~reset;
    assign gnt     = w_issue ? w_arb_gnt : '0;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_idx == TAG_W'(i)) begin
                w_sel_a = req_dataa[32*i +: 32];
                w_sel_b = req_datab[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr   <= '0;
            r_vpipe <= '0;
            r_dataa <= '0;
            r_datab <= '0;
        end else begin
            r_vpipe <= {r_vpipe[LATENCY-1:0], w_issue};
            if (w_issue) begin
                r_ptr   <= (w_arb_idx == c_LAST) ? '0 : w_arb_idx + 1'b1;
                r_dataa <= w_sel_a;
                r_datab <= w_sel_b;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= w_arb_idx;
            for (int k = 1; k <= LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign cmp_dataa  = r_dataa;
    assign cmp_datab  = r_datab;
    // Core runs whenever any operation is still travelling through it.
    assign cmp_clk_en = |r_vpipe;

`ifdef FP_CMP_UNORDERED_EN
    assign w_unord = ~(cmp_aeb | cmp_agb | cmp_alb);
`else
    assign w_unord = 1'b0;
`endif

    assign w_flags = {w_unord, cmp_alb, cmp_agb, cmp_aeb};

    always_comb begin
        rsp_valid  = '0;
        rsp_result = '0;
        if (r_vpipe[LATENCY]) begin
            rsp_valid[r_tag[LATENCY]] = 1'b1;
            rsp_result                = cmp_pack_result(w_flags);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_compare_arbiter.sv
// ============================================================================
// Module      : tb_fp_compare_arbiter
// Description : Directed bench for fp_compare_arbiter with a clk_en-gated
//               behavioural model of the compare core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_compare_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LATENCY = 2;
    localparam int NROWS   = 31;

    localparam logic [127:0] DA_DEF = {32'hBF800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] DB_DEF = {32'hC0000000, 32'h40400000, 32'h3F800000, 32'h40000000};
    localparam logic [127:0] DA_NAN = {32'hBF800000, 32'h40400000, 32'h40000000, 32'h7FC00000};
`ifdef FP_CMP_UNORDERED_EN
    localparam logic [31:0] NAN_RES = 32'h8;
`else
    localparam logic [31:0] NAN_RES = 32'h0;
`endif

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_dataa;
    logic [127:0] req_datab;
    logic [3:0]   gnt;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_result;
    logic         cmp_clk_en;
    logic [31:0]  cmp_dataa;
    logic [31:0]  cmp_datab;
    logic         cmp_aeb;
    logic         cmp_agb;
    logic         cmp_alb;

    int checks = 0;
    int errors = 0;

    fp_compare_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LATENCY (LATENCY)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .req        (req),
        .req_dataa  (req_dataa),
        .req_datab  (req_datab),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .cmp_clk_en (cmp_clk_en),
        .cmp_dataa  (cmp_dataa),
        .cmp_datab  (cmp_datab),
        .cmp_aeb    (cmp_aeb),
        .cmp_agb    (cmp_agb),
        .cmp_alb    (cmp_alb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {alb, agb, aeb}; all zero when either operand is NaN.
    function automatic logic [2:0] fcmp(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ka;
        logic [31:0] kb;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return 3'b000;
        if (a[30:0] == 0 && b[30:0] == 0)
            return 3'b001;
        ka = a[31] ? ~a : (a | 32'h80000000);
        kb = b[31] ? ~b : (b | 32'h80000000);
        if (ka == kb) return 3'b001;
        if (ka > kb)  return 3'b010;
        return 3'b100;
    endfunction

    logic [2:0] m_pipe [0:LATENCY-1];
    always @(posedge clk) begin
        if (cmp_clk_en) begin
            m_pipe[0] <= fcmp(cmp_dataa, cmp_datab);
            for (int k = 1; k < LATENCY; k++) m_pipe[k] <= m_pipe[k-1];
        end
    end
    assign {cmp_alb, cmp_agb, cmp_aeb} = m_pipe[LATENCY-1];

    typedef struct packed {
        logic [3:0]   req;
        logic [127:0] da;
        logic [3:0]   gnt;
        logic [3:0]   rv;
        logic [31:0]  res;
    } vec_t;

    vec_t vecs [NROWS];

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g,
                                input logic [3:0] v, input logic [31:0] res);
        vec_t t;
        t.req = r; t.da = DA_DEF; t.gnt = g; t.rv = v; t.res = res;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [127:0] da);
        @(posedge clk);
        #1;
        req       = r;
        req_dataa = da;
        req_datab = DB_DEF;
        #1;
    endtask

    initial begin
        int         lat;
        logic       seen;
        logic [3:0] cap_rv;
        logic [31:0] cap_res;

        for (int i = 0; i < NROWS; i++) vecs[i] = mk(4'h0, 4'h0, 4'h0, 32'h0);
        vecs[0]  = mk(4'h1, 4'h1, 4'h0, 32'h0);
        vecs[3]  = mk(4'h0, 4'h0, 4'h1, 32'h4);
        vecs[4]  = mk(4'hF, 4'h2, 4'h0, 32'h0);
        vecs[5]  = mk(4'hF, 4'h4, 4'h0, 32'h0);
        vecs[6]  = mk(4'hF, 4'h8, 4'h0, 32'h0);
        vecs[7]  = mk(4'hF, 4'h1, 4'h2, 32'h2);
        vecs[8]  = mk(4'hF, 4'h2, 4'h4, 32'h1);
        vecs[9]  = mk(4'hF, 4'h4, 4'h8, 32'h2);
        vecs[10] = mk(4'hF, 4'h8, 4'h1, 32'h4);
        vecs[11] = mk(4'hF, 4'h1, 4'h2, 32'h2);
        vecs[12] = mk(4'h0, 4'h0, 4'h4, 32'h1);
        vecs[13] = mk(4'h0, 4'h0, 4'h8, 32'h2);
        vecs[14] = mk(4'h0, 4'h0, 4'h1, 32'h4);
        vecs[15] = mk(4'h4, 4'h4, 4'h0, 32'h0);
        vecs[16] = mk(4'h4, 4'h4, 4'h0, 32'h0);
        vecs[17] = mk(4'h4, 4'h4, 4'h0, 32'h0);
        vecs[18] = mk(4'h4, 4'h4, 4'h4, 32'h1);
        vecs[19] = mk(4'h0, 4'h0, 4'h4, 32'h1);
        vecs[20] = mk(4'h0, 4'h0, 4'h4, 32'h1);
        vecs[21] = mk(4'h0, 4'h0, 4'h4, 32'h1);
        vecs[22] = mk(4'h1, 4'h1, 4'h0, 32'h0);
        vecs[22].da = DA_NAN;
        vecs[25] = mk(4'h0, 4'h0, 4'h1, NAN_RES);
        vecs[26] = mk(4'h9, 4'h8, 4'h0, 32'h0);
        vecs[27] = mk(4'h9, 4'h1, 4'h0, 32'h0);
        vecs[29] = mk(4'h0, 4'h0, 4'h8, 32'h2);
        vecs[30] = mk(4'h0, 4'h0, 4'h1, 32'h4);

        reset     = 1'b1;
        req       = '0;
        req_dataa = DA_DEF;
        req_datab = DB_DEF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset gnt",        {28'h0, gnt},       32'h0);
        chk("reset rsp_valid",  {28'h0, rsp_valid}, 32'h0);
        chk("reset rsp_result", rsp_result,         32'h0);
        chk("reset clk_en",     {31'h0, cmp_clk_en}, 32'h0);
        chk("reset dataa",      cmp_dataa,          32'h0);
        chk("reset datab",      cmp_datab,          32'h0);

        for (int i = 0; i < NROWS; i++) begin
            step(vecs[i].req, vecs[i].da);
            chk($sformatf("row%0d gnt", i),    {28'h0, gnt},       {28'h0, vecs[i].gnt});
            chk($sformatf("row%0d rsp_v", i),  {28'h0, rsp_valid}, {28'h0, vecs[i].rv});
            chk($sformatf("row%0d result", i), rsp_result,         vecs[i].res);
        end

        // Core clock gating after idle, then wake-up on a fresh issue.
        repeat (5) step(4'h0, DA_DEF);
        chk("idle clk_en", {31'h0, cmp_clk_en}, 32'h0);
        step(4'h2, DA_DEF);
        chk("wake gnt", {28'h0, gnt}, 32'h2);
        lat  = 0;
        seen = 1'b0;
        cap_rv  = '0;
        cap_res = '0;
        for (int k = 1; k <= 10; k++) begin
            step(4'h0, DA_DEF);
            if (k == 1) begin
                chk("wake clk_en", {31'h0, cmp_clk_en}, 32'h1);
                chk("wake dataa",  cmp_dataa, 32'h40000000);
                chk("wake datab",  cmp_datab, 32'h3F800000);
            end
            if (!seen && rsp_valid != 0) begin
                seen    = 1'b1;
                lat     = k;
                cap_rv  = rsp_valid;
                cap_res = rsp_result;
            end
        end
        chk("wake latency", lat, 3);
        chk("wake rsp_v",   {28'h0, cap_rv}, 32'h2);
        chk("wake result",  cap_res, 32'h2);

        // Reset with two operations in flight and pointer away from zero.
        step(4'hF, DA_DEF);
        chk("pre-rst gnt a", {28'h0, gnt}, 32'h4);
        step(4'h5, DA_DEF);
        chk("pre-rst gnt b", {28'h0, gnt}, 32'h1);
        @(posedge clk);
        #1;
        req   = 4'h0;
        #1;
        reset = 1'b1;
        #1;
        chk("mid-rst clk_en", {31'h0, cmp_clk_en}, 32'h0);
        chk("mid-rst dataa",  cmp_dataa, 32'h0);
        chk("mid-rst gnt",    {28'h0, gnt}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #2;
            if (rsp_valid != 0) seen = 1'b1;
        end
        chk("post-rst no rsp", {31'h0, seen}, 32'h0);
        step(4'hF, DA_DEF);
        chk("post-rst ptr0 gnt", {28'h0, gnt}, 32'h1);
        step(4'h8, DA_DEF);
        chk("post-rst req3 gnt", {28'h0, gnt}, 32'h8);
        step(4'h0, DA_DEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
